gate_array_unit: RTL and testbench
==================================

# gate_array_unit

Parametrised, registered multi-lane logic gate that generalises the single 2-input NAND into WIDTH lanes of an N_IN-input gate with a runtime-selectable function. Operands arrive through a valid/ready handshake and leave through a one-entry output register. An optional built-in sweep engine applies every input combination to lane 0 and captures the resulting truth table. The block sits wherever the design needs a configurable bitwise reduction stage, and is also the team's self-checking replacement for hand-written gate testbenches.

## Interface
- WIDTH, 8: number of independent bit lanes (1..64).
- N_IN, 2: inputs per gate (2..4).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand word valid.
- in_ready  out  1  block can accept an operand word this cycle.
- in_data  in  N_IN*WIDTH  operand k occupies in_data[k*WIDTH +: WIDTH].
- mode  in  3  gate function, sampled with in_data.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  registered result.
- sweep_start  in  1  single-cycle request to run a truth-table sweep.
- sweep_busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when the sweep completes.
- truth_table  out  2**N_IN  bit c = lane-0 result for input combination c.

## Operation
- mode encoding: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR (odd parity), 5 XNOR, 6 NOT of operand 0, 7 BUF of operand 0. Each lane reduces the N_IN operand bits at its position.
- Handshake: a transfer occurs when in_valid && in_ready. On a transfer, out_data <= f(mode, in_data) and out_valid <= 1.
- in_ready = (state==IDLE) && !sweep_start && (!out_valid || out_ready). This allows full throughput of one word per cycle when out_ready is held high.
- When out_valid && out_ready and no new transfer occurs, out_valid <= 0. out_data holds its last value.
- in_data and mode must not be assumed stable beyond the transfer cycle.
- Sweep FSM has three states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP when sweep_start && !out_valid. In that case mode is latched, cnt <= 0 and truth_table <= 0.
  - If out_valid is high, sweep_start is ignored and is not queued.
  - SWEEP: each cycle, truth_table[cnt] <= f(latched mode, operand k bit = cnt[k]) and cnt <= cnt+1. When cnt == 2**N_IN-1, go to DONE.
  - DONE: sweep_done = 1 for this one cycle, then IDLE.
- sweep_busy = (state != IDLE).
- While busy, in_ready = 0 and out_valid stays 0.
- sweep_start has priority over in_valid in the same cycle.
- truth_table holds its value until the next accepted sweep_start or reset.

## Timing
- Datapath latency: result is visible in out_data/out_valid the cycle after the transfer edge.
- Sweep latency: start is sampled at edge E. truth_table bits are written at edges E+1 .. E+2**N_IN. sweep_done is high during the cycle after edge E+2**N_IN. in_ready can return high in the cycle after that.
- Total busy time: 2**N_IN + 1 cycles.
- Reset (rst_n low, asynchronous, at any point including mid-sweep):
  - out_valid=0, out_data=0, truth_table=0.
  - sweep_busy=0, sweep_done=0, state=IDLE, cnt=0.
  - A partial sweep is discarded.
- in_ready after reset: high in the first cycle with rst_n high, unless sweep_start is asserted.

## Configuration
- GATE_SWEEP_EN defined: the sweep FSM, counter and truth_table register are compiled in, as described above.
- GATE_SWEEP_EN undefined:
  - sweep_start is ignored.
  - sweep_busy, sweep_done and truth_table are tied to 0.
  - in_ready = !out_valid || out_ready.
  - The datapath is unchanged.

## Test plan
- NAND, N_IN=2, WIDTH=8: in_data={8'hF0,8'hCC} -> out_data=8'h3F with out_valid high one cycle later; modes 0/2/4 on the same operands give 8'hC0/8'hFC/8'h3C.
- Back-pressure: out_ready=0 with a second word offered -> in_ready=0, out_data holds 8'h3F. Then out_ready=1 -> next result appears one cycle later with no word lost or duplicated.
- Sweep NAND, N_IN=2 -> truth_table=4'b0111 and sweep_done pulses 5 cycles after start. Sweep XOR with N_IN=3 -> 8'h96.
- sweep_start while out_valid=1 -> ignored, sweep_busy stays 0. sweep_start and in_valid in the same cycle with out_valid=0 -> sweep runs and the word is not accepted.
- rst_n pulsed low for 1 cycle in the middle of the N_IN=4 sweep -> all outputs 0 immediately. A restarted AND sweep then gives truth_table=16'h8000.
- Build without GATE_SWEEP_EN: sweep_start pulses -> truth_table stays 0 and the datapath result matches the first scenario.

Source files
------------

// File: rtl/gate_array_unit.sv
// gate_array_unit: WIDTH lanes of an N_IN-input gate with runtime-selectable function behind a
// valid/ready handshake. Define GATE_SWEEP_EN to build in the lane-0 truth-table sweep engine.
module gate_array_unit #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N_IN  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_IN*WIDTH-1:0]   in_data,
   input  logic [2:0]              mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   input  logic                    sweep_start,
   output logic                    sweep_busy,
   output logic                    sweep_done,
   output logic [2**N_IN-1:0]      truth_table
);

   // One gate evaluated over the N_IN operand bits of a single lane.
   function automatic logic f_bit(input logic [2:0] m, input logic [N_IN-1:0] ops);
      case (m)
         3'd0:    return &ops;
         3'd1:    return ~&ops;
         3'd2:    return |ops;
         3'd3:    return ~|ops;
         3'd4:    return ^ops;
         3'd5:    return ~^ops;
         3'd6:    return ~ops[0];
         default: return ops[0];
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] f_gate(input logic [2:0] m,
                                               input logic [N_IN*WIDTH-1:0] d);
      logic [WIDTH-1:0] res;
      logic [N_IN-1:0]  ops;
      res = '0;
      ops = '0;
      for (int l = 0; l < int'(WIDTH); l++) begin
         for (int k = 0; k < int'(N_IN); k++) ops[k] = d[k*int'(WIDTH) + l];
         res[l] = f_bit(m, ops);
      end
      return res;
   endfunction

   logic             w_xfer;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;

   assign w_xfer    = in_valid && in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

   // One-entry output register; out_data keeps its last value when drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= f_gate(mode, in_data);
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef GATE_SWEEP_EN
   localparam int unsigned N_COMB = 2**N_IN;

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [N_IN-1:0]   r_cnt;
   logic [2:0]        r_mode;
   logic [N_COMB-1:0] r_tt;
   logic              w_start;
   logic              w_sweep_bit;

   // A sweep may only begin with the output register empty; otherwise the request is dropped.
   assign w_start     = (r_state == S_IDLE) && sweep_start && !r_out_valid;
   assign w_sweep_bit = f_bit(r_mode, r_cnt);
   assign truth_table = r_tt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      sweep_busy  = 1'b1;
      sweep_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            sweep_busy = 1'b0;
            in_ready   = !sweep_start && (!r_out_valid || out_ready);
            if (w_start) w_state_nxt = S_SWEEP;
         end
         S_SWEEP: begin
            if (&r_cnt) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            sweep_done  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Counter value doubles as the operand pattern: operand k bit = r_cnt[k].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_mode <= '0;
         r_tt   <= '0;
      end else if (w_start) begin
         r_cnt  <= '0;
         r_mode <= mode;
         r_tt   <= '0;
      end else if (r_state == S_SWEEP) begin
         r_tt[r_cnt] <= w_sweep_bit;
         r_cnt       <= r_cnt + 1'b1;
      end
   end
`else
   logic w_unused_sweep_start;

   assign w_unused_sweep_start = sweep_start;
   assign in_ready             = !r_out_valid || out_ready;
   assign sweep_busy           = 1'b0;
   assign sweep_done           = 1'b0;
   assign truth_table          = '0;
`endif

endmodule

// File: tb/tb_gate_array_unit.sv
// Bench for gate_array_unit: three instances (N_IN = 2, 3, 4; WIDTH = 8) share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_gate_array_unit;

`ifdef GATE_SWEEP_EN
   localparam bit SWEEP_EN = 1'b1;
`else
   localparam bit SWEEP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  mode = 3'd0;
   logic [31:0] in_data = 32'd0;
   logic        out_ready = 1'b1;
   logic        sweep_start = 1'b0;

   logic        rdy  [3];
   logic        ov   [3];
   logic        busy [3];
   logic        done [3];
   logic [7:0]  od   [3];
   logic [15:0] tt   [3];
   logic [3:0]  tt2;
   logic [7:0]  tt3;
   logic [15:0] tt4;

   assign tt[0] = {12'd0, tt2};
   assign tt[1] = {8'd0, tt3};
   assign tt[2] = tt4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gate_array_unit #(.WIDTH(8), .N_IN(2)) u_n2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
      .in_data(in_data[15:0]), .mode(mode), .out_valid(ov[0]), .out_ready(out_ready),
      .out_data(od[0]), .sweep_start(sweep_start), .sweep_busy(busy[0]),
      .sweep_done(done[0]), .truth_table(tt2));

   gate_array_unit #(.WIDTH(8), .N_IN(3)) u_n3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
      .in_data(in_data[23:0]), .mode(mode), .out_valid(ov[1]), .out_ready(out_ready),
      .out_data(od[1]), .sweep_start(sweep_start), .sweep_busy(busy[1]),
      .sweep_done(done[1]), .truth_table(tt3));

   gate_array_unit #(.WIDTH(8), .N_IN(4)) u_n4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
      .in_data(in_data), .mode(mode), .out_valid(ov[2]), .out_ready(out_ready),
      .out_data(od[2]), .sweep_start(sweep_start), .sweep_busy(busy[2]),
      .sweep_done(done[2]), .truth_table(tt4));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference gate: count the ones among the n operand bits of each lane.
   function automatic logic [7:0] gate(input logic [2:0] m, input logic [31:0] d, input int n);
      logic [7:0] r;
      int ones;
      r = '0;
      for (int l = 0; l < 8; l++) begin
         ones = 0;
         for (int k = 0; k < n; k++) ones += int'(d[k*8 + l]);
         case (m)
            3'd0: r[l] = (ones == n);
            3'd1: r[l] = (ones != n);
            3'd2: r[l] = (ones > 0);
            3'd3: r[l] = (ones == 0);
            3'd4: r[l] = (ones % 2 == 1);
            3'd5: r[l] = (ones % 2 == 0);
            3'd6: r[l] = !d[l];
            default: r[l] = d[l];
         endcase
      end
      return r;
   endfunction

   function automatic logic [15:0] full_tt(input logic [2:0] m, input int n);
      logic [15:0] t;
      logic [31:0] d;
      logic [7:0]  r;
      t = '0;
      for (int c = 0; c < (1 << n); c++) begin
         d = '0;
         for (int k = 0; k < n; k++) d[k*8] = ((c >> k) & 1) != 0;
         r = gate(m, d, n);
         t[c] = r[0];
      end
      return t;
   endfunction

   // Reference model state: m_busy counts remaining busy cycles (1 = done cycle).
   logic        m_ov   [3] = '{1'b0, 1'b0, 1'b0};
   logic [7:0]  m_od   [3] = '{8'd0, 8'd0, 8'd0};
   int          m_busy [3] = '{0, 0, 0};
   logic [15:0] m_tt   [3] = '{16'd0, 16'd0, 16'd0};
   logic [15:0] m_pend [3] = '{16'd0, 16'd0, 16'd0};

   function automatic logic exp_ready(input int d);
      if (SWEEP_EN) return (m_busy[d] == 0) && !sweep_start && (!m_ov[d] || out_ready);
      return !m_ov[d] || out_ready;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 3; d++) begin
            m_ov[d]   <= 1'b0;
            m_od[d]   <= 8'd0;
            m_busy[d] <= 0;
            m_tt[d]   <= 16'd0;
            m_pend[d] <= 16'd0;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (SWEEP_EN && m_busy[d] == 0 && sweep_start && !m_ov[d]) begin
               m_busy[d] <= (1 << (d + 2)) + 1;
               m_tt[d]   <= 16'd0;
               m_pend[d] <= full_tt(mode, d + 2);
            end else if (m_busy[d] > 0) begin
               m_busy[d] <= m_busy[d] - 1;
               if (m_busy[d] == 2) m_tt[d] <= m_pend[d];
            end
            if (in_valid && exp_ready(d)) begin
               m_ov[d] <= 1'b1;
               m_od[d] <= gate(mode, in_data, d + 2);
            end else if (m_ov[d] && out_ready) begin
               m_ov[d] <= 1'b0;
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         check($sformatf("mon in_ready n%0d", d + 2), 64'(rdy[d]), 64'(exp_ready(d)));
         check($sformatf("mon out_valid n%0d", d + 2), 64'(ov[d]), 64'(m_ov[d]));
         check($sformatf("mon out_data n%0d", d + 2), 64'(od[d]), 64'(m_od[d]));
         check($sformatf("mon sweep_busy n%0d", d + 2), 64'(busy[d]), 64'(m_busy[d] != 0));
         check($sformatf("mon sweep_done n%0d", d + 2), 64'(done[d]), 64'(m_busy[d] == 1));
         if (m_busy[d] <= 1)
            check($sformatf("mon truth_table n%0d", d + 2), 64'(tt[d]), 64'(m_tt[d]));
      end
   end

   typedef struct {
      logic [2:0]  m;
      logic [31:0] d;
      logic [7:0]  e2;
      logic [7:0]  e3;
      logic [7:0]  e4;
   } vec_t;

   vec_t vecs [11];

   task automatic idle(input int n);
      in_valid    = 1'b0;
      sweep_start = 1'b0;
      out_ready   = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_sweep(input logic [2:0] m, input logic [15:0] e2, input logic [15:0] e3,
                            input logic [15:0] e4);
      int first [3];
      logic [15:0] e [3];
      first = '{-1, -1, -1};
      e     = '{e2, e3, e4};
      mode        = m;
      in_valid    = 1'b0;
      out_ready   = 1'b1;
      sweep_start = 1'b1;
      @(posedge clk);
      #1;
      sweep_start = 1'b0;
      mode        = 3'($urandom);
      for (int c = 1; c <= 24; c++) begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 3; d++) if (done[d] && first[d] < 0) first[d] = c;
      end
      for (int d = 0; d < 3; d++) begin
         check($sformatf("sweep latency n%0d", d + 2), 64'(first[d]),
               64'(SWEEP_EN ? (1 << (d + 2)) : -1));
         check($sformatf("sweep truth_table n%0d", d + 2), 64'(tt[d]),
               64'(SWEEP_EN ? e[d] : 16'd0));
      end
   endtask

   initial begin
      vecs[0]  = '{3'd0, 32'hFFFF_F0CC, 8'hC0, 8'hC0, 8'hC0};
      vecs[1]  = '{3'd1, 32'hFFFF_F0CC, 8'h3F, 8'h3F, 8'h3F};
      vecs[2]  = '{3'd2, 32'hFFFF_F0CC, 8'hFC, 8'hFF, 8'hFF};
      vecs[3]  = '{3'd3, 32'hFFFF_F0CC, 8'h03, 8'h00, 8'h00};
      vecs[4]  = '{3'd4, 32'hFFFF_F0CC, 8'h3C, 8'hC3, 8'h3C};
      vecs[5]  = '{3'd5, 32'hFFFF_F0CC, 8'hC3, 8'h3C, 8'hC3};
      vecs[6]  = '{3'd6, 32'hFFFF_F0CC, 8'h33, 8'h33, 8'h33};
      vecs[7]  = '{3'd7, 32'hFFFF_F0CC, 8'hCC, 8'hCC, 8'hCC};
      vecs[8]  = '{3'd0, 32'hFFFF_FFFF, 8'hFF, 8'hFF, 8'hFF};
      vecs[9]  = '{3'd3, 32'h0000_0000, 8'hFF, 8'hFF, 8'hFF};
      vecs[10] = '{3'd4, 32'h0F0F_00FF, 8'hFF, 8'hF0, 8'hFF};

      // Reset state.
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset in_ready n%0d", d + 2), 64'(rdy[d]), 64'd1);
         check($sformatf("reset out_valid n%0d", d + 2), 64'(ov[d]), 64'd0);
         check($sformatf("reset out_data n%0d", d + 2), 64'(od[d]), 64'd0);
         check($sformatf("reset truth_table n%0d", d + 2), 64'(tt[d]), 64'd0);
      end

      // Directed vectors at full throughput.
      for (int i = 0; i < 11; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         mode      = vecs[i].m;
         in_data   = vecs[i].d;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d out_valid", i), 64'(ov[0]), 64'd1);
         check($sformatf("vec%0d n2", i), 64'(od[0]), 64'(vecs[i].e2));
         check($sformatf("vec%0d n3", i), 64'(od[1]), 64'(vecs[i].e3));
         check($sformatf("vec%0d n4", i), 64'(od[2]), 64'(vecs[i].e4));
      end
      idle(2);

      // Back-pressure: second word must wait, then land exactly once.
      in_valid  = 1'b1;
      out_ready = 1'b0;
      mode      = 3'd1;
      in_data   = 32'hFFFF_F0CC;
      @(posedge clk);
      #1;
      check("bp first result", 64'(od[0]), 64'h3F);
      mode    = 3'd0;
      in_data = 32'hFFFF_0FAA;
      #1 check("bp in_ready stalled", 64'(rdy[0]), 64'd0);
      @(posedge clk);
      #1;
      check("bp hold data", 64'(od[0]), 64'h3F);
      check("bp hold valid", 64'(ov[0]), 64'd1);
      out_ready = 1'b1;
      #1 check("bp in_ready released", 64'(rdy[0]), 64'd1);
      @(posedge clk);
      #1;
      check("bp second result", 64'(od[0]), 64'h0A);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp drained valid", 64'(ov[0]), 64'd0);
      check("bp drained data", 64'(od[0]), 64'h0A);
      idle(2);

      run_sweep(3'd1, 16'h0007, 16'h007F, 16'h7FFF);

      // sweep_start with a result pending is dropped.
      in_valid  = 1'b1;
      out_ready = 1'b0;
      mode      = 3'd1;
      in_data   = 32'hFFFF_F0CC;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      sweep_start = 1'b1;
      @(posedge clk);
      #1;
      sweep_start = 1'b0;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("ignored start busy n%0d", d + 2), 64'(busy[d]), 64'd0);
         check($sformatf("ignored start valid n%0d", d + 2), 64'(ov[d]), 64'd1);
      end
      idle(3);

      // sweep_start wins over in_valid in the same cycle.
      mode        = 3'd4;
      in_data     = 32'hFFFF_F0CC;
      in_valid    = 1'b1;
      sweep_start = 1'b1;
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      sweep_start = 1'b0;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("prio busy n%0d", d + 2), 64'(busy[d]), 64'(SWEEP_EN));
         check($sformatf("prio word dropped n%0d", d + 2), 64'(ov[d]), 64'(!SWEEP_EN));
      end
      idle(24);
      check("xor sweep n2", 64'(tt[0]), 64'(SWEEP_EN ? 16'h0006 : 16'h0000));
      check("xor sweep n3", 64'(tt[1]), 64'(SWEEP_EN ? 16'h0096 : 16'h0000));
      check("xor sweep n4", 64'(tt[2]), 64'(SWEEP_EN ? 16'h6996 : 16'h0000));

      // Asynchronous reset in the middle of a sweep.
      in_valid  = 1'b1;
      mode      = 3'd4;
      in_data   = 32'hFFFF_F0CC;
      @(posedge clk);
      #1 in_valid = 1'b0;
      idle(1);
      mode        = 3'd0;
      sweep_start = 1'b1;
      @(posedge clk);
      #1 sweep_start = 1'b0;
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("midreset busy n%0d", d + 2), 64'(busy[d]), 64'd0);
         check($sformatf("midreset done n%0d", d + 2), 64'(done[d]), 64'd0);
         check($sformatf("midreset tt n%0d", d + 2), 64'(tt[d]), 64'd0);
         check($sformatf("midreset valid n%0d", d + 2), 64'(ov[d]), 64'd0);
         check($sformatf("midreset data n%0d", d + 2), 64'(od[d]), 64'd0);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_sweep(3'd0, 16'h0008, 16'h0080, 16'h8000);

      // Random traffic with occasional sweep requests.
      for (int i = 0; i < 600; i++) begin
         in_valid    = ($urandom % 4) != 0;
         out_ready   = ($urandom % 3) != 0;
         mode        = 3'($urandom);
         in_data     = 32'($urandom);
         sweep_start = ($urandom % 25) == 0;
         @(posedge clk);
         #1;
      end
      idle(24);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
